mem_access_ctrl: RTL



---
 rtl/mem_access_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller: one outstanding req/gnt/rvalid transaction,
// store lane placement with byte enables and load lane extraction with extension.
module mem_access_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ex_req_i,
   input  logic                  ex_we_i,
   input  logic [1:0]            ex_data_type_i,
   input  logic                  ex_sign_ext_i,
   input  logic [ADDR_WIDTH-1:0] ex_addr_i,
   input  logic [DATA_WIDTH-1:0] ex_wdata_i,
   input  logic [4:0]            ex_rd_addr_i,
   output logic                  ex_ready_o,
   output logic                  data_req_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   output logic [ADDR_WIDTH-1:0] data_addr_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [DATA_WIDTH-1:0] data_wdata_o,
   input  logic [DATA_WIDTH-1:0] data_rdata_i,
   output logic                  wb_valid_o,
   output logic [DATA_WIDTH-1:0] wb_rdata_o,
   output logic [4:0]            wb_rd_addr_o,
   output logic                  misaligned_o
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic                  w_accept;
   logic                  w_misaligned;
   logic [1:0]            w_offset;
   logic [3:0]            w_be;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic [DATA_WIDTH-1:0] w_ext;

   logic                  r_we;
   logic                  r_sign;
   logic [1:0]            r_type;
   logic [1:0]            r_offset;
   logic [4:0]            r_rd;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [3:0]            r_be;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_wb_valid;
   logic [DATA_WIDTH-1:0] r_wb_rdata;
   logic [4:0]            r_wb_rd;
   logic                  r_misaligned;

   assign w_offset   = ex_addr_i[1:0];
   assign w_accept   = ex_req_i && (r_state == IDLE);
   assign ex_ready_o = (r_state == IDLE);
   assign data_req_o = (r_state == REQ);

   // Alignment check and store lane placement for the op presented by EX
   always_comb begin
      w_misaligned = 1'b0;
      w_be         = 4'b1111;
      w_wdata      = ex_wdata_i;
      case (ex_data_type_i)
         2'b01: begin
            w_misaligned = w_offset[0];
            w_wdata      = {2{ex_wdata_i[15:0]}};
            if (ex_we_i) w_be = 4'b0011 << w_offset;
            else         w_be = 4'b1111;
         end
         2'b10: begin
            w_wdata = {4{ex_wdata_i[7:0]}};
            if (ex_we_i) w_be = 4'b0001 << w_offset;
            else         w_be = 4'b1111;
         end
         default: begin
            // word and the reserved encoding share word behaviour
            w_misaligned = (w_offset != 2'b00);
         end
      endcase
   end

   // Load lane extraction and sign/zero extension of the returned word
   always_comb begin
      w_shifted = data_rdata_i >> {r_offset, 3'b000};
      case (r_type)
         2'b01: begin
            if (r_sign) w_ext = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            else        w_ext = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
         end
         2'b10: begin
            if (r_sign) w_ext = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            else        w_ext = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
         end
         default: w_ext = w_shifted;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_misaligned) w_state_next = REQ;
            else                           w_state_next = IDLE;
         end
         REQ: begin
            if (data_gnt_i) w_state_next = WAIT;
            else            w_state_next = REQ;
         end
         WAIT: begin
            if (data_rvalid_i) w_state_next = IDLE;
            else               w_state_next = WAIT;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Transaction latches, writeback result and misalignment pulse
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_we         <= 1'b0;
         r_sign       <= 1'b0;
         r_type       <= 2'b00;
         r_offset     <= 2'b00;
         r_rd         <= 5'd0;
         r_addr       <= '0;
         r_be         <= 4'b0000;
         r_wdata      <= '0;
         r_wb_valid   <= 1'b0;
         r_wb_rdata   <= '0;
         r_wb_rd      <= 5'd0;
         r_misaligned <= 1'b0;
      end else begin
         r_wb_valid   <= 1'b0;
         r_misaligned <= 1'b0;
         if (w_accept && w_misaligned) begin
            r_misaligned <= 1'b1;
         end else if (w_accept) begin
            r_we     <= ex_we_i;
            r_sign   <= ex_sign_ext_i;
            r_type   <= ex_data_type_i;
            r_offset <= w_offset;
            r_rd     <= ex_rd_addr_i;
            r_addr   <= {ex_addr_i[ADDR_WIDTH-1:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
         end
         // stores complete silently; only loads produce a writeback pulse
         if ((r_state == WAIT) && data_rvalid_i && !r_we) begin
            r_wb_valid <= 1'b1;
            r_wb_rdata <= w_ext;
            r_wb_rd    <= r_rd;
         end
      end
   end

   assign data_addr_o  = r_addr;
   assign data_we_o    = r_we;
   assign data_be_o    = r_be;
   assign data_wdata_o = r_wdata;
   assign wb_valid_o   = r_wb_valid;
   assign wb_rdata_o   = r_wb_rdata;
   assign wb_rd_addr_o = r_wb_rd;
   assign misaligned_o = r_misaligned;

endmodule
